rom_port_arbiter: RTL
=====================

Name: rom_port_arbiter

Overview:
- Shares the single asynchronous instruction/constant ROM read port between two requesters.
- Requester IF is the CPU instruction fetch. Requester LS is load/store reads of constant tables (quantisation and Huffman tables for the JPEG encoder).
- Grants at most one read per cycle. Registers each response into a per-port holding slot with valid/ready backpressure.
- Bounds instruction-fetch starvation with a counter.

Parameters:
- WIDTH, 32: address and data width. Matches ROM word size.
- DEPTH, 2048: ROM depth in words. Word index is address[WIDTH-1:2].
- STARVE_LIMIT, 4: number of consecutive cycles IF may be denied while requesting before it is forced priority.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request. Held with if_addr stable until if_gnt.
- if_addr  in  WIDTH  IF byte address.
- if_gnt  out  1  IF request accepted this cycle (combinational).
- if_rvalid  out  1  IF response slot full.
- if_rready  in  1  IF consumes response when if_rvalid=1.
- if_rdata  out  WIDTH  IF response data.
- if_err  out  1  IF response is an error (misaligned or out of range).
- ls_req, ls_addr, ls_gnt, ls_rvalid, ls_rready, ls_rdata, ls_err: same directions, widths and meanings as the IF ports, for the LS requester.
- rom_address  out  WIDTH  address driven to the ROM.
- rom_rdata  in  WIDTH  ROM asynchronous read data.
- if_starved  out  1  high while the starvation counter equals STARVE_LIMIT.

Behaviour:
- Reset, synchronous and active-high:
  - rvalid, rdata and err for both ports = 0.
  - Starvation counter = 0.
  - Reset overrides everything on that edge. Any in-flight response is discarded and any same-cycle grant is lost; the requester must re-request.
- Port eligibility:
  - A port is eligible when req=1 AND (rvalid=0 OR rready=1), i.e. its slot is empty or draining this cycle.
  - An ineligible port gets gnt=0 regardless of priority.
- Priority (combinational, one grant per cycle):
  - If counter == STARVE_LIMIT and IF is eligible: grant IF.
  - Else if LS is eligible: grant LS.
  - Else if IF is eligible: grant IF.
  - Else: no grant.
- ROM address:
  - rom_address = granted port's address.
  - With no grant, rom_address = 0.
  - Async ROM, so rom_rdata is valid in the same cycle.
- Response, 1-cycle latency:
  - On the edge after a grant, the granted port's slot loads rvalid=1.
  - Valid address: rdata = rom_rdata, err=0.
  - Error address (addr[1:0] != 0, or addr[WIDTH-1:2] >= DEPTH): rdata = 0, err = 1, and the ROM value is ignored.
  - Error responses still consume a grant.
- Slot drain:
  - rvalid && rready && no new grant for that port: rvalid, rdata and err clear to 0 next edge.
  - Drain and new grant in the same cycle: the slot reloads with the new data. Back-to-back throughput is 1 per cycle per port.
  - rvalid=1 && rready=0: rdata and err stay stable, and the port cannot be granted.
- Starvation counter, updated each edge:
  - Increments, saturating at STARVE_LIMIT, when IF is eligible and LS is granted.
  - Clears to 0 when IF is granted or if_req=0.
  - Holds otherwise.
- Assertion: if_gnt and ls_gnt are never high together.
- Requester rule: a requester must not change addr or drop req while req=1 and gnt=0.
  - The arbiter does not check this rule.
  - Behaviour if it is broken is undefined; the bench flags it.

Test Plan:
- IF only, if_addr=0x0000_0010, rready=1 → if_gnt=1 same cycle; rom_address=0x10; next cycle if_rvalid=1, if_rdata=ROM word 4, if_err=0.
- IF and LS request together, both rready=1, ls_addr=0x40, if_addr=0x8 → cycle 0: ls_gnt=1, rom_address=0x40; cycle 1: if_gnt=1, rom_address=0x8. Responses appear on cycles 1 and 2.
- LS requests every cycle (new address each grant), IF requests continuously → IF denied 4 cycles with if_starved=1 on cycle 4; IF granted in cycle 4; counter returns to 0; LS resumes in cycle 5.
- if_rready=0 after first IF response, IF re-requests → if_gnt=0 and if_rdata stable until if_rready=1. In that cycle if_gnt=1, and the slot reloads next cycle with if_rvalid continuously 1.
- Errors → ls_addr=0x6: next cycle ls_rvalid=1, ls_err=1, ls_rdata=0. ls_addr=DEPTH*4=0x2000: same result.
- Reset asserted the cycle after a grant, with the response pending → all rvalid/err/rdata=0 and counter=0 after the edge; no response is delivered for the aborted request.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Shares one asynchronous ROM read port between instruction fetch (IF) and load/store (LS),
// with a registered response slot per port and a bound on how long IF can be starved.
module rom_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 2048,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  input  logic             if_rready,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_err,
  input  logic             ls_req,
  input  logic [WIDTH-1:0] ls_addr,
  output logic             ls_gnt,
  output logic             ls_rvalid,
  input  logic             ls_rready,
  output logic [WIDTH-1:0] ls_rdata,
  output logic             ls_err,
  output logic [WIDTH-1:0] rom_address,
  input  logic [WIDTH-1:0] rom_rdata,
  output logic             if_starved
);

  localparam int              CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   LIMIT   = CW'(STARVE_LIMIT);
  localparam logic [WIDTH-3:0] DEPTH_W = (WIDTH-2)'(DEPTH);

  logic             r_if_rvalid;
  logic [WIDTH-1:0] r_if_rdata;
  logic             r_if_err;
  logic             r_ls_rvalid;
  logic [WIDTH-1:0] r_ls_rdata;
  logic             r_ls_err;
  logic [CW-1:0]    r_starve_cnt;

  logic w_if_elig;
  logic w_ls_elig;
  logic w_if_gnt;
  logic w_ls_gnt;
  logic w_starved;
  logic w_if_addr_err;
  logic w_ls_addr_err;

  function automatic logic addr_err(input logic [WIDTH-1:0] addr);
    return (addr[1:0] != 2'b00) || (addr[WIDTH-1:2] >= DEPTH_W);
  endfunction

  // A port may only be granted when its slot is empty or being drained this cycle.
  assign w_if_elig     = if_req && (!r_if_rvalid || if_rready);
  assign w_ls_elig     = ls_req && (!r_ls_rvalid || ls_rready);
  assign w_starved     = (r_starve_cnt == LIMIT);
  assign w_if_addr_err = addr_err(if_addr);
  assign w_ls_addr_err = addr_err(ls_addr);

  always_comb begin
    w_if_gnt = 1'b0;
    w_ls_gnt = 1'b0;
    if (w_starved && w_if_elig) begin
      w_if_gnt = 1'b1;
    end else if (w_ls_elig) begin
      w_ls_gnt = 1'b1;
    end else if (w_if_elig) begin
      w_if_gnt = 1'b1;
    end
  end

  always_comb begin
    rom_address = '0;
    if (w_if_gnt) begin
      rom_address = if_addr;
    end else if (w_ls_gnt) begin
      rom_address = ls_addr;
    end
  end

  // Error responses still occupy the slot, but never expose the ROM word.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_if_err    <= 1'b0;
    end else if (w_if_gnt) begin
      r_if_rvalid <= 1'b1;
      r_if_err    <= w_if_addr_err;
      r_if_rdata  <= w_if_addr_err ? '0 : rom_rdata;
    end else if (r_if_rvalid && if_rready) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_if_err    <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ls_rvalid <= 1'b0;
      r_ls_rdata  <= '0;
      r_ls_err    <= 1'b0;
    end else if (w_ls_gnt) begin
      r_ls_rvalid <= 1'b1;
      r_ls_err    <= w_ls_addr_err;
      r_ls_rdata  <= w_ls_addr_err ? '0 : rom_rdata;
    end else if (r_ls_rvalid && ls_rready) begin
      r_ls_rvalid <= 1'b0;
      r_ls_rdata  <= '0;
      r_ls_err    <= 1'b0;
    end
  end

  // Counts cycles IF was ready to go but lost to LS; saturates at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_if_gnt || !if_req) begin
      r_starve_cnt <= '0;
    end else if (w_if_elig && w_ls_gnt && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end
  end

  assign if_gnt     = w_if_gnt;
  assign ls_gnt     = w_ls_gnt;
  assign if_rvalid  = r_if_rvalid;
  assign if_rdata   = r_if_rdata;
  assign if_err     = r_if_err;
  assign ls_rvalid  = r_ls_rvalid;
  assign ls_rdata   = r_ls_rdata;
  assign ls_err     = r_ls_err;
  assign if_starved = w_starved;

  a_one_grant: assert property (@(posedge clock) !(if_gnt && ls_gnt));

endmodule
